// File: rtl/snd_cmd_sched.sv
// rtl/snd_cmd_sched.sv - sound-command scheduler: queues main-CPU commands, issues them by NMI, paces IRQs.
// Define SND_CMD_FIFO_EN for a 4-deep command queue; otherwise a single overwrite slot is used.
module snd_cmd_sched #(
  parameter int IRQ_HALF = 16667,
  parameter int GAP_CYC  = 8
) (
  input  logic       clk4M,
  input  logic       reset_n,
  input  logic [7:0] sndno,
  input  logic       sndstart,
  input  logic       com_rd,
  input  logic       cpu_nmia,
  input  logic       cpu_irqa,
  output logic       cpu_nmi,
  output logic       cpu_irq,
  output logic [7:0] comlatch,
  output logic [2:0] fifo_cnt,
  output logic       busy,
  output logic       ovf
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_READ, S_GAP} state_t;

  localparam logic [15:0] TMR_LAST = 16'(IRQ_HALF - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);

  state_t      r_state;
  logic        r_sndstart, r_armed, r_com_rd;
  logic        r_nmi, r_irq, r_busy, r_ovf;
  logic [7:0]  r_latch;
  logic [2:0]  r_cnt;
  logic [15:0] r_gap, r_timer;
  logic        w_push, w_pop, w_full;
  logic [7:0]  w_head;

  // r_armed keeps a strobe already high at reset release from counting as an edge
  assign w_push = sndstart & ~r_sndstart & r_armed;
  assign w_pop  = (r_state == S_IDLE) && (r_cnt != 3'd0);

`ifdef SND_CMD_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic       w_acc;

  assign w_full = (r_cnt == 3'd4);
  assign w_head = r_mem[r_rd_ptr];
  assign w_acc  = w_push && (!w_full || w_pop);

  always_ff @(posedge clk4M) begin
    if (w_acc) r_mem[r_wr_ptr] <= sndno;
  end

  always_ff @(posedge clk4M or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_cnt    <= 3'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_acc) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_acc} - {2'b00, w_pop};
      if (w_push && !w_acc) r_ovf <= 1'b1;
    end
  end
`else
  logic [7:0] r_slot;

  assign w_full = r_cnt[0];
  assign w_head = r_slot;

  // A push into an occupied, unissued slot replaces it; a same-cycle pop has already taken the old value
  always_ff @(posedge clk4M or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= 8'd0;
      r_cnt  <= 3'd0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_slot <= sndno;
      if (w_push)     r_cnt <= 3'd1;
      else if (w_pop) r_cnt <= 3'd0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk4M or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_nmi      <= 1'b0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
      r_latch    <= 8'd0;
      r_gap      <= 16'd0;
      r_timer    <= 16'd0;
      r_sndstart <= 1'b0;
      r_armed    <= 1'b0;
      r_com_rd   <= 1'b0;
    end else begin
      r_sndstart <= sndstart;
      r_armed    <= 1'b1;
      r_com_rd   <= com_rd;

      // Timer wrap sets the IRQ and takes priority over an acknowledge in the same cycle
      if (r_timer == TMR_LAST) begin
        r_timer <= 16'd0;
        r_irq   <= 1'b1;
      end else begin
        r_timer <= r_timer + 16'd1;
        if (cpu_irqa) r_irq <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_latch <= w_head;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_nmi   <= 1'b1;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (cpu_nmia) begin
            r_nmi   <= 1'b0;
            r_state <= S_WAIT_READ;
          end
        end
        S_WAIT_READ: begin
          if (com_rd && !r_com_rd) begin
            if (GAP_CYC == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_gap   <= GAP_LOAD;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 16'd0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        default: begin
          r_nmi   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_nmi  = r_nmi;
  assign cpu_irq  = r_irq;
  assign comlatch = r_latch;
  assign fifo_cnt = r_cnt;
  assign busy     = r_busy;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_snd_cmd_sched.sv
// tb/tb_snd_cmd_sched.sv - randomized self-checking bench for snd_cmd_sched against a queue model.
module tb_snd_cmd_sched;
  localparam int IRQ_HALF = 10;
  localparam int GAP = 3;
`ifdef SND_CMD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk4M = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sndno = 8'd0;
  logic       sndstart = 1'b0, com_rd = 1'b0, cpu_nmia = 1'b0, cpu_irqa = 1'b0;
  logic       cpu_nmi, cpu_irq, busy, ovf;
  logic [7:0] comlatch;
  logic [2:0] fifo_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_nmi_cyc = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0;

  snd_cmd_sched #(.IRQ_HALF(IRQ_HALF), .GAP_CYC(GAP)) dut (
    .clk4M(clk4M), .reset_n(reset_n), .sndno(sndno), .sndstart(sndstart),
    .com_rd(com_rd), .cpu_nmia(cpu_nmia), .cpu_irqa(cpu_irqa),
    .cpu_nmi(cpu_nmi), .cpu_irq(cpu_irq), .comlatch(comlatch),
    .fifo_cnt(fifo_cnt), .busy(busy), .ovf(ovf)
  );

  always #5 clk4M = ~clk4M;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk4M);
    #1;
    cyc++;
  endtask

  // Model of the pending (not yet issued) commands: a full queue drops, a single slot overwrites
  task automatic m_push(input logic [7:0] c);
    if (q.size() < DEPTH) q.push_back(c);
    else begin
      m_ovf = 1'b1;
      if (DEPTH == 1) q[0] = c;
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; sndstart = 1'b0; sndno = 8'd0;
    com_rd = 1'b0; cpu_nmia = 1'b0; cpu_irqa = 1'b0;
    step(); step();
    reset_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic push(input logic [7:0] c);
    sndno = c; sndstart = 1'b1;
    step();
    sndstart = 1'b0;
    step();
  endtask

  task automatic serve(input logic [7:0] exp_cmd, input int ack_dly, input int rd_dly);
    int n = 0;
    while (cpu_nmi !== 1'b1 && n < 20) begin step(); n++; end
    tests++;
    if (cpu_nmi !== 1'b1) begin
      fails++;
      $display("FAIL serve_nmi_timeout: cpu_nmi=%b required 1 for cmd %h", cpu_nmi, exp_cmd);
      return;
    end
    last_nmi_cyc = cyc;
    tests++;
    if (comlatch !== exp_cmd) begin
      fails++; $display("FAIL serve_comlatch: got %h required %h", comlatch, exp_cmd);
    end
    repeat (ack_dly) step();
    cpu_nmia = 1'b1; step(); cpu_nmia = 1'b0;
    tests++;
    if (cpu_nmi !== 1'b0) begin
      fails++; $display("FAIL serve_nmi_clear: cpu_nmi=%b required 0", cpu_nmi);
    end
    repeat (rd_dly) step();
    com_rd = 1'b1; step(); com_rd = 1'b0;
    repeat (GAP) begin
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL serve_gap_busy: busy=%b required 1", busy); end
      step();
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL serve_busy_end: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL reset_nmi: %b required 0", cpu_nmi); end
    tests++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: %b required 0", cpu_irq); end
    tests++; if (comlatch !== 8'h00) begin fails++; $display("FAIL reset_comlatch: %h required 00", comlatch); end
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL reset_fifo_cnt: %0d required 0", fifo_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: %b required 0", busy); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: %b required 0", ovf); end
  endtask

  task automatic test_single();
    reset_dut();
    step();
    sndno = 8'h21; sndstart = 1'b1;
    step();
    sndstart = 1'b0;
    tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL single_push_cnt: %0d required 1", fifo_cnt); end
    step();
    tests++; if (comlatch !== 8'h21) begin fails++; $display("FAIL single_latch: %h required 21", comlatch); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: %b required 1", busy); end
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL single_nmi_early: %b required 0", cpu_nmi); end
    step();
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL single_nmi_2cyc: %b required 1", cpu_nmi); end
    serve(8'h21, $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] a, b;
      int t1;
      a = 8'($urandom); b = 8'($urandom);
      reset_dut();
      step();
      push(a);
      push(b);
      serve(a, 0, 0);
      t1 = last_nmi_cyc;
      serve(b, 0, 0);
      tests++;
      if (last_nmi_cyc - t1 != 4 + GAP) begin
        fails++; $display("FAIL b2b_spacing: %0d cycles required %0d", last_nmi_cyc - t1, 4 + GAP);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] base;
    base = 8'($urandom);
    reset_dut();
    step();
    push(base);
    for (int i = 1; i < 6; i++) begin
      push(base + 8'(i));
      m_push(base + 8'(i));
    end
    tests++; if (fifo_cnt !== 3'(q.size())) begin fails++; $display("FAIL burst_cnt: %0d required %0d", fifo_cnt, q.size()); end
    tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL burst_ovf: %b required %b", ovf, m_ovf); end
    serve(base, $urandom_range(0, 2), $urandom_range(0, 2));
    while (q.size() > 0) serve(q.pop_front(), $urandom_range(0, 2), $urandom_range(0, 2));
    repeat (12) step();
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL burst_extra_nmi: %b required 0", cpu_nmi); end
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL burst_drain_cnt: %0d required 0", fifo_cnt); end
  endtask

  task automatic test_full_pop();
    logic [7:0] a, x, h;
    a = 8'($urandom); x = 8'($urandom);
    reset_dut();
    step();
    push(a);
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      push(c);
      m_push(c);
    end
    tests++; if (fifo_cnt !== 3'(DEPTH)) begin fails++; $display("FAIL fullpop_fill: %0d required %0d", fifo_cnt, DEPTH); end
    serve(a, 0, 0);
    sndno = x; sndstart = 1'b1;
    step();
    sndstart = 1'b0;
    h = q.pop_front();
    m_push(x);
    tests++; if (fifo_cnt !== 3'(DEPTH)) begin fails++; $display("FAIL fullpop_cnt: %0d required %0d", fifo_cnt, DEPTH); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fullpop_ovf: %b required 0", ovf); end
    serve(h, 1, 1);
    while (q.size() > 0) serve(q.pop_front(), 0, 1);
  endtask

  task automatic test_overwrite();
    logic [7:0] a;
    a = 8'($urandom);
    reset_dut();
    step();
    push(a);
    push(8'h10); m_push(8'h10);
    push(8'h11); m_push(8'h11);
    tests++; if (fifo_cnt !== 3'(q.size())) begin fails++; $display("FAIL ovw_cnt: %0d required %0d", fifo_cnt, q.size()); end
    tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL ovw_ovf: %b required %b", ovf, m_ovf); end
    serve(a, 1, 0);
    while (q.size() > 0) serve(q.pop_front(), 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom);
    reset_dut();
    step();
    push(8'($urandom));
    repeat (3) push(8'($urandom));
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL rmid_pre_nmi: %b required 1", cpu_nmi); end
    #3;
    reset_n = 1'b0;
    sndstart = 1'b1;
    #1;
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL rmid_nmi: %b required 0", cpu_nmi); end
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL rmid_cnt: %0d required 0", fifo_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: %b required 0", busy); end
    tests++; if (comlatch !== 8'h00) begin fails++; $display("FAIL rmid_latch: %h required 00", comlatch); end
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 6) sndstart = 1'b0;
      tests++;
      if (cpu_nmi !== 1'b0 || busy !== 1'b0 || fifo_cnt !== 3'd0) begin
        fails++; $display("FAIL rmid_quiet: nmi=%b busy=%b cnt=%0d required 0/0/0", cpu_nmi, busy, fifo_cnt);
      end
    end
    push(b);
    serve(b, 0, 1);
  endtask

  task automatic test_timer();
    logic exp_irq;
    exp_irq = 1'b0;
    reset_dut();
    for (int k = 1; k <= 35; k++) begin
      cpu_irqa = (k == 20) || ($urandom_range(0, 3) == 0);
      step();
      if (k % IRQ_HALF == 0) exp_irq = 1'b1;
      else if (cpu_irqa) exp_irq = 1'b0;
      tests++;
      if (cpu_irq !== exp_irq) begin
        fails++; $display("FAIL timer_irq at cycle %0d: %b required %b", k, cpu_irq, exp_irq);
      end
    end
    cpu_irqa = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_full_pop();
    test_overwrite();
    test_reset_mid();
    test_timer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
